// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: states, opcodes,
// ALU-op codes and trap causes.
package mcpu_pkg;

  typedef enum logic [4:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecute,
    StAluWb,
    StImmExec,
    StImmWb,
    StBranch,
    StBge,
    StJump,
    StJalWb,
    StMdStart,
    StMdWait,
    StMdWb,
    StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpBltz  = 6'd1;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpSlti  = 6'd10;
  localparam logic [5:0] OpAndi  = 6'd12;
  localparam logic [5:0] OpBge   = 6'd14;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  localparam logic [5:0] FnNop  = 6'h00;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnMult = 6'h18;
  localparam logic [5:0] FnDiv  = 6'h1A;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnXor  = 6'h26;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluFunct = 3'd2;
  localparam logic [2:0] AluAnd   = 3'd3;
  localparam logic [2:0] AluSlt   = 3'd4;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseUndef   = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;

endpackage

// File: rtl/mcpu_wait_timer.sv
// Counts consecutive cycles a handshake stays low; flags the cycle in which the
// MEM_TIMEOUT-th low cycle occurs. MEM_TIMEOUT = 0 never expires.
module mcpu_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit Enabled = (MEM_TIMEOUT != 0);
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_expired = Enabled && i_count && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (Enabled && i_count && !o_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mcpu_ctrl_fsm_v2.sv
// Multicycle MIPS-subset control FSM with variable-latency memory, mul/div
// handshake and registered trap entry. Moore outputs except fetch enables.
module mcpu_ctrl_fsm_v2
  import mcpu_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STATE_W     = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_op,
  input  logic [5:0]         i_funct,
  input  logic               i_mem_ready,
  input  logic               i_md_done,
  output logic               o_pc_write,
  output logic               o_pc_write_cond,
  output logic               o_ir_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_reg_write,
  output logic [1:0]         o_iord,
  output logic [1:0]         o_mem_to_reg,
  output logic [1:0]         o_pc_source,
  output logic [1:0]         o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_reg_dst,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_md_start,
  output logic               o_epc_write,
  output logic [1:0]         o_cause,
  output logic [STATE_W-1:0] o_state
);

  state_e     state_q, state_d;
  logic [2:0] imm_op_q, imm_op_d;
  logic [1:0] cause_q, cause_d;
  logic       wait_low;
  logic       expired;
  logic [2:0] alu_op;

  always_comb begin
    wait_low = 1'b0;
    unique case (state_q)
      StFetch, StMemRead, StMemWrite: wait_low = !i_mem_ready;
      StMdWait:                       wait_low = !i_md_done;
      default:                        wait_low = 1'b0;
    endcase
  end

  // Any state change re-arms the timer, so each wait state starts from zero.
  mcpu_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (state_d != state_q),
    .i_count  (wait_low),
    .o_expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    imm_op_d = imm_op_q;
    cause_d  = cause_q;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        if (i_mem_ready) begin
          state_d = StDecode;
        end else if (expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        unique case (i_op)
          OpRtype: begin
            unique case (i_funct)
              FnNop:               state_d = StFetch;
              FnSllv, FnAdd, FnXor: state_d = StExecute;
              FnMult, FnDiv:       state_d = StMdStart;
              default: begin
                state_d = StTrap;
                cause_d = CauseUndef;
              end
            endcase
          end
          OpBltz, OpBeq:       state_d = StBranch;
          OpBge:               state_d = StBge;
          OpJ:                 state_d = StJump;
          OpJal:               state_d = StJalWb;
          OpAddi, OpLw, OpSw:  state_d = StMemAdr;
          OpSlti: begin
            state_d  = StImmExec;
            imm_op_d = AluSlt;
          end
          OpAndi: begin
            state_d  = StImmExec;
            imm_op_d = AluAnd;
          end
          default: begin
            state_d = StTrap;
            cause_d = CauseUndef;
          end
        endcase
      end
      StMemAdr: begin
        unique case (i_op)
          OpLw:    state_d = StMemRead;
          OpSw:    state_d = StMemWrite;
          OpAddi:  state_d = StImmWb;
          default: state_d = StFetch;
        endcase
      end
      StMemRead: begin
        if (i_mem_ready) begin
          state_d = StMemWb;
        end else if (expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StMemWrite: begin
        if (i_mem_ready) begin
          state_d = StFetch;
        end else if (expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StExecute:  state_d = StAluWb;
      StImmExec:  state_d = StImmWb;
      StMdStart:  state_d = StMdWait;
      StMdWait: begin
        if (i_md_done) begin
          state_d = StMdWb;
        end else if (expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StReset;
      imm_op_q <= AluAdd;
      cause_q  <= CauseNone;
    end else begin
      state_q  <= state_d;
      imm_op_q <= imm_op_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_write     = 1'b0;
    o_iord          = 2'd0;
    o_mem_to_reg    = 2'd0;
    o_pc_source     = 2'd0;
    o_alu_src_a     = 2'd0;
    o_alu_src_b     = 2'd0;
    o_reg_dst       = 2'd0;
    alu_op          = AluAdd;
    o_md_start      = 1'b0;
    o_epc_write     = 1'b0;
    unique case (state_q)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'd1;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      StDecode: o_alu_src_b = 2'd3;
      StMemAdr: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
      end
      StMemRead: begin
        o_iord     = 2'd1;
        o_mem_read = 1'b1;
      end
      StMemWb: begin
        o_mem_to_reg = 2'd1;
        o_reg_write  = 1'b1;
      end
      StMemWrite: begin
        o_iord      = 2'd1;
        o_mem_write = 1'b1;
      end
      StExecute: begin
        o_alu_src_a = 2'd1;
        alu_op      = AluFunct;
      end
      StAluWb: begin
        o_reg_dst   = 2'd1;
        o_reg_write = 1'b1;
      end
      StImmExec: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
        alu_op      = imm_op_q;
      end
      StImmWb: o_reg_write = 1'b1;
      StBranch, StBge: begin
        o_alu_src_a     = 2'd1;
        alu_op          = (state_q == StBge) ? AluSlt : AluSub;
        o_pc_source     = 2'd1;
        o_pc_write_cond = 1'b1;
      end
      StJump: begin
        o_pc_source = 2'd2;
        o_pc_write  = 1'b1;
      end
      StJalWb: begin
        o_reg_dst   = 2'd2;
        o_reg_write = 1'b1;
        o_pc_source = 2'd2;
        o_pc_write  = 1'b1;
      end
      StMdStart: o_md_start = 1'b1;
      StMdWb: begin
        o_reg_dst    = 2'd1;
        o_mem_to_reg = 2'd2;
        o_reg_write  = 1'b1;
      end
      StTrap: begin
        o_epc_write = 1'b1;
        o_pc_source = 2'd3;
        o_pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_alu_op = ALUOP_W'(alu_op);
  assign o_cause  = cause_q;
  assign o_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_mcpu_ctrl_fsm_v2.sv
// Directed bench: lw/sw/div/R-type/branch/imm/nop flows, undefined opcode,
// reset mid-instruction, and memory timeout on a second instance.
module tb_mcpu_ctrl_fsm_v2;
  import mcpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {pc_w, pc_w_cond, ir_w, mem_rd, mem_wr, reg_w, md_start, epc_w,
  //                  iord, mem_to_reg, pc_src, src_a, src_b, reg_dst, alu_op}
  localparam logic [22:0] CZero      = 23'd0;
  localparam logic [22:0] CFetchWait = {8'b0001_0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0};
  localparam logic [22:0] CFetchRdy  = {8'b1011_0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0};
  localparam logic [22:0] CDecode    = {8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0};
  localparam logic [22:0] CMemAdr    = {8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 3'd0};
  localparam logic [22:0] CMemRead   = {8'b0001_0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [22:0] CMemWb     = {8'b0000_0100, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [22:0] CMemWrite  = {8'b0000_1000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [22:0] CTrap      = {8'b1000_0001, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [22:0] CMdStart   = {8'b0000_0010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [22:0] CMdWb      = {8'b0000_0100, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0};
  localparam logic [22:0] CExecute   = {8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 3'd2};
  localparam logic [22:0] CAluWb     = {8'b0000_0100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0};
  localparam logic [22:0] CBranch    = {8'b0100_0000, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 3'd1};
  localparam logic [22:0] CImmSlt    = {8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 3'd4};
  localparam logic [22:0] CImmWb     = {8'b0000_0100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};

  logic       rst_n, mem_ready, md_done, rst_t, ready_t;
  logic [5:0] op, funct;

  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] iord, mem_to_reg, pc_source, alu_src_a, alu_src_b, reg_dst, cause;
  logic [2:0] alu_op;
  logic       md_start, epc_write;
  logic [4:0] state;

  logic       pc_write_t, pc_write_cond_t, ir_write_t, mem_read_t, mem_write_t, reg_write_t;
  logic [1:0] iord_t, mem_to_reg_t, pc_source_t, alu_src_a_t, alu_src_b_t, reg_dst_t, cause_t;
  logic [2:0] alu_op_t;
  logic       md_start_t, epc_write_t;
  logic [4:0] state_t;

  logic [22:0] ctl, ctl_t;
  assign ctl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, md_start,
                epc_write, iord, mem_to_reg, pc_source, alu_src_a, alu_src_b, reg_dst, alu_op};
  assign ctl_t = {pc_write_t, pc_write_cond_t, ir_write_t, mem_read_t, mem_write_t, reg_write_t,
                  md_start_t, epc_write_t, iord_t, mem_to_reg_t, pc_source_t, alu_src_a_t,
                  alu_src_b_t, reg_dst_t, alu_op_t};

  mcpu_ctrl_fsm_v2 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct(funct),
    .i_mem_ready(mem_ready), .i_md_done(md_done),
    .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond), .o_ir_write(ir_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_reg_write(reg_write),
    .o_iord(iord), .o_mem_to_reg(mem_to_reg), .o_pc_source(pc_source),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_reg_dst(reg_dst),
    .o_alu_op(alu_op), .o_md_start(md_start), .o_epc_write(epc_write),
    .o_cause(cause), .o_state(state)
  );

  mcpu_ctrl_fsm_v2 #(.MEM_TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst_n(rst_t), .i_op(op), .i_funct(funct),
    .i_mem_ready(ready_t), .i_md_done(md_done),
    .o_pc_write(pc_write_t), .o_pc_write_cond(pc_write_cond_t), .o_ir_write(ir_write_t),
    .o_mem_read(mem_read_t), .o_mem_write(mem_write_t), .o_reg_write(reg_write_t),
    .o_iord(iord_t), .o_mem_to_reg(mem_to_reg_t), .o_pc_source(pc_source_t),
    .o_alu_src_a(alu_src_a_t), .o_alu_src_b(alu_src_b_t), .o_reg_dst(reg_dst_t),
    .o_alu_op(alu_op_t), .o_md_start(md_start_t), .o_epc_write(epc_write_t),
    .o_cause(cause_t), .o_state(state_t)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; rst_t = 1'b1; mem_ready = 1'b0; md_done = 1'b0; ready_t = 1'b0;
    op = 6'd0; funct = 6'd0;
    #1 rst_n = 1'b0; rst_t = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(StReset));
    chk("rst_ctl", 32'(ctl), 32'(CZero));
    chk("rst_cause", 32'(cause), 32'(CauseNone));

    // lw, ready held high
    @(negedge clk);
    rst_n = 1'b1; op = OpLw; mem_ready = 1'b1;
    tick(); chk("lw_fetch", 32'(state), 32'(StFetch)); chk("lw_fetch_ctl", 32'(ctl), 32'(CFetchRdy));
    tick(); chk("lw_decode", 32'(state), 32'(StDecode)); chk("lw_dec_ctl", 32'(ctl), 32'(CDecode));
    tick(); chk("lw_memadr", 32'(state), 32'(StMemAdr)); chk("lw_adr_ctl", 32'(ctl), 32'(CMemAdr));
    tick(); chk("lw_memrd", 32'(state), 32'(StMemRead)); chk("lw_rd_ctl", 32'(ctl), 32'(CMemRead));
    tick(); chk("lw_memwb", 32'(state), 32'(StMemWb)); chk("lw_wb_ctl", 32'(ctl), 32'(CMemWb));

    // sw with three wait cycles
    op = OpSw;
    tick(); chk("sw_fetch", 32'(state), 32'(StFetch));
    tick(); chk("sw_decode", 32'(state), 32'(StDecode));
    mem_ready = 1'b0;
    tick(); chk("sw_memadr", 32'(state), 32'(StMemAdr));
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sw_wait_st", 32'(state), 32'(StMemWrite));
      chk("sw_wait_ctl", 32'(ctl), 32'(CMemWrite));
    end
    tick(); mem_ready = 1'b1; #1;
    chk("sw_last_st", 32'(state), 32'(StMemWrite)); chk("sw_last_ctl", 32'(ctl), 32'(CMemWrite));
    tick(); chk("sw_to_fetch", 32'(state), 32'(StFetch)); chk("sw_cause0", 32'(cause), 32'(0));

    // undefined opcode
    op = 6'd63;
    tick(); chk("undef_dec", 32'(state), 32'(StDecode));
    tick(); chk("undef_trap", 32'(state), 32'(StTrap)); chk("undef_ctl", 32'(ctl), 32'(CTrap));
    chk("undef_cause", 32'(cause), 32'(CauseUndef));
    tick(); chk("undef_fetch", 32'(state), 32'(StFetch)); chk("undef_hold", 32'(cause), 32'(1));

    // div, done on the fifth wait cycle
    op = OpRtype; funct = FnDiv;
    tick(); chk("div_dec", 32'(state), 32'(StDecode));
    tick(); chk("div_start", 32'(state), 32'(StMdStart)); chk("div_start_ctl", 32'(ctl), 32'(CMdStart));
    tick(); chk("div_wait1", 32'(state), 32'(StMdWait)); chk("div_wait_ctl", 32'(ctl), 32'(CZero));
    tick(); tick(); tick();
    chk("div_wait4", 32'(state), 32'(StMdWait));
    tick(); md_done = 1'b1; #1; chk("div_wait5", 32'(state), 32'(StMdWait));
    tick(); md_done = 1'b0;
    chk("div_wb", 32'(state), 32'(StMdWb)); chk("div_wb_ctl", 32'(ctl), 32'(CMdWb));
    tick(); chk("div_fetch", 32'(state), 32'(StFetch));

    // add (R-type)
    funct = FnAdd;
    tick(); tick(); chk("add_exec", 32'(state), 32'(StExecute)); chk("add_ex_ctl", 32'(ctl), 32'(CExecute));
    tick(); chk("add_wb", 32'(state), 32'(StAluWb)); chk("add_wb_ctl", 32'(ctl), 32'(CAluWb));
    tick(); chk("add_fetch", 32'(state), 32'(StFetch));

    // beq
    op = OpBeq;
    tick(); tick(); chk("beq_st", 32'(state), 32'(StBranch)); chk("beq_ctl", 32'(ctl), 32'(CBranch));
    tick(); chk("beq_fetch", 32'(state), 32'(StFetch));

    // slti
    op = OpSlti;
    tick(); tick(); chk("slti_st", 32'(state), 32'(StImmExec)); chk("slti_ctl", 32'(ctl), 32'(CImmSlt));
    tick(); chk("slti_wb", 32'(state), 32'(StImmWb)); chk("slti_wb_ctl", 32'(ctl), 32'(CImmWb));
    tick(); chk("slti_fetch", 32'(state), 32'(StFetch));

    // nop: two cycles
    op = OpRtype; funct = FnNop;
    tick(); chk("nop_dec", 32'(state), 32'(StDecode));
    tick(); chk("nop_fetch", 32'(state), 32'(StFetch));

    // reset during MEM_WB of a lw
    op = OpLw;
    tick(); tick(); tick(); tick();
    chk("rmid_memwb", 32'(state), 32'(StMemWb));
    #1 rst_n = 1'b0; #1;
    chk("rmid_state", 32'(state), 32'(StReset)); chk("rmid_ctl", 32'(ctl), 32'(CZero));
    chk("rmid_cause", 32'(cause), 32'(CauseNone));
    @(negedge clk); rst_n = 1'b1;
    tick(); chk("rmid_fetch", 32'(state), 32'(StFetch));

    // timeout instance, MEM_TIMEOUT = 4
    @(negedge clk); rst_t = 1'b1; ready_t = 1'b0;
    tick(); chk("to_fetch1", 32'(state_t), 32'(StFetch)); chk("to_f_ctl", 32'(ctl_t), 32'(CFetchWait));
    tick(); tick(); tick(); chk("to_fetch4", 32'(state_t), 32'(StFetch));
    tick(); chk("to_trap", 32'(state_t), 32'(StTrap)); chk("to_trap_ctl", 32'(ctl_t), 32'(CTrap));
    chk("to_cause", 32'(cause_t), 32'(CauseTimeout));
    tick(); chk("to_refetch", 32'(state_t), 32'(StFetch));
    chk("to_refetch_ctl", 32'(ctl_t), 32'(CFetchWait)); chk("to_hold", 32'(cause_t), 32'(2));
    tick(); tick(); tick(); ready_t = 1'b1; #1;
    chk("to_edge_st", 32'(state_t), 32'(StFetch));
    tick(); chk("to_ready_wins", 32'(state_t), 32'(StDecode));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
